// File: rtl/tri_st_add_seg_pipe_if.sv
// Handshake and operand/result bundle for the segmented carry-select adder pipe.
// Bit 0 of every vector is the most significant bit.
interface tri_st_add_seg_pipe_if #(
    parameter int WIDTH = 64
);
    localparam int NSEG = WIDTH / 8;

    logic             i_valid;
    logic             i_ready;
    logic [0:WIDTH-1] i_a;
    logic [0:WIDTH-1] i_b;
    logic             i_cin;
    logic             i_sub;
    logic             i_simd;

    logic             o_valid;
    logic             o_ready;
    logic [0:WIDTH-1] o_sum;
    logic [0:NSEG-1]  o_co;
    logic             o_ovf;

    modport master (
        output i_valid, i_a, i_b, i_cin, i_sub, i_simd, o_ready,
        input  i_ready, o_valid, o_sum, o_co, o_ovf
    );

    modport slave (
        input  i_valid, i_a, i_b, i_cin, i_sub, i_simd, o_ready,
        output i_ready, o_valid, o_sum, o_co, o_ovf
    );
endinterface

// File: rtl/tri_st_add_seg_pipe.sv
// Two-stage carry-select adder/subtractor built from 8-bit segments, with
// valid/ready back-pressure and a SIMD mode that isolates each segment.
module tri_st_add_seg_pipe #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    tri_st_add_seg_pipe_if.slave bus
);
    localparam int NSEG = WIDTH / 8;

    logic                    s1_valid;
    logic                    s2_valid;
    logic                    s2_adv;
    logic                    s1_adv;
    logic                    accept;

    logic [0:WIDTH-1]        bx;
    logic                    ci;
    logic [8:0]              seg_t;
    logic [0:NSEG-1][7:0]    d_sum0;
    logic [0:NSEG-1][7:0]    d_sum1;
    logic [0:NSEG-1]         d_gs;
    logic [0:NSEG-1]         d_ps;

    logic [0:NSEG-1][7:0]    s1_sum0;
    logic [0:NSEG-1][7:0]    s1_sum1;
    logic [0:NSEG-1]         s1_gs;
    logic [0:NSEG-1]         s1_ps;
    logic                    s1_ci;
    logic                    s1_simd;
    logic                    s1_a_msb;
    logic                    s1_bx_msb;

    logic                    carry;
    logic [0:WIDTH-1]        nx_sum;
    logic [0:NSEG-1]         nx_co;
    logic                    nx_ovf;

    logic [0:WIDTH-1]        s2_sum;
    logic [0:NSEG-1]         s2_co;
    logic                    s2_ovf;

    // Ready looks only at pipe occupancy and the consumer, never at i_valid.
    assign s2_adv      = ~s2_valid | bus.o_ready;
    assign bus.i_ready = ~s1_valid | s2_adv;
    assign accept      = bus.i_valid & bus.i_ready;
    assign s1_adv      = s1_valid & s2_adv;

    assign bx = bus.i_sub ? ~bus.i_b : bus.i_b;
    assign ci = bus.i_sub | bus.i_cin;

    // Stage 1: both carry-in candidates per segment plus generate/propagate.
    always_comb begin
        seg_t  = '0;
        d_sum0 = '0;
        d_sum1 = '0;
        d_gs   = '0;
        d_ps   = '0;
        for (int s = 0; s < NSEG; s++) begin
            seg_t     = {1'b0, bus.i_a[s*8 +: 8]} + {1'b0, bx[s*8 +: 8]};
            d_sum0[s] = seg_t[7:0];
            d_sum1[s] = seg_t[7:0] + 8'd1;
            d_gs[s]   = seg_t[8];
            d_ps[s]   = &(bus.i_a[s*8 +: 8] ^ bx[s*8 +: 8]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sum0   <= '0;
            s1_sum1   <= '0;
            s1_gs     <= '0;
            s1_ps     <= '0;
            s1_ci     <= 1'b0;
            s1_simd   <= 1'b0;
            s1_a_msb  <= 1'b0;
            s1_bx_msb <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (accept) begin
                s1_sum0   <= d_sum0;
                s1_sum1   <= d_sum1;
                s1_gs     <= d_gs;
                s1_ps     <= d_ps;
                s1_ci     <= ci;
                s1_simd   <= bus.i_simd;
                s1_a_msb  <= bus.i_a[0];
                s1_bx_msb <= bx[0];
            end
        end
    end

    // Stage 2: resolve segment carries from the least significant segment
    // upward; SIMD feeds every segment the operation's own carry-in.
    always_comb begin
        carry  = s1_ci;
        nx_sum = '0;
        nx_co  = '0;
        for (int s = NSEG - 1; s >= 0; s--) begin
            nx_sum[s*8 +: 8] = carry ? s1_sum1[s] : s1_sum0[s];
            nx_co[s]         = s1_gs[s] | (s1_ps[s] & carry);
            carry            = s1_simd ? s1_ci : nx_co[s];
        end
        nx_ovf = ~s1_simd & (s1_a_msb == s1_bx_msb) & (nx_sum[0] != s1_a_msb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_co    <= '0;
            s2_ovf   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum <= nx_sum;
                s2_co  <= nx_co;
                s2_ovf <= nx_ovf;
            end
        end
    end

    assign bus.o_valid = s2_valid;
    assign bus.o_sum   = s2_sum;
    assign bus.o_co    = s2_co;
    assign bus.o_ovf   = s2_ovf;
endmodule

// File: tb/tb_tri_st_add_seg_pipe.sv
// Scoreboard bench for tri_st_add_seg_pipe: driver pushes reference results,
// a separate monitor pops and compares whenever a result is handed over.
module tb_tri_st_add_seg_pipe;
    typedef struct {
        logic [63:0] sum;
        logic [7:0]  co;
        logic        ovf;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   ready_sel = 1;
    bit   lat_mode = 0;
    exp_t sb[$];

    tri_st_add_seg_pipe_if #(.WIDTH(64)) bus ();

    tri_st_add_seg_pipe #(.WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on whole words or independent bytes.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub, input logic simd);
        exp_t        e;
        logic [63:0] bx;
        logic [63:0] m;
        logic        ci;
        logic [64:0] t;
        logic [8:0]  l;
        int          n;
        bx = sub ? ~b : b;
        ci = sub ? 1'b1 : cin;
        e.sum = '0;
        e.co = '0;
        e.ovf = 1'b0;
        e.cyc = 0;
        e.chk_lat = 1'b0;
        if (simd) begin
            for (int k = 0; k < 8; k++) begin
                l = {1'b0, a[63-8*k -: 8]} + {1'b0, bx[63-8*k -: 8]} + {8'd0, ci};
                e.sum[63-8*k -: 8] = l[7:0];
                e.co[7-k] = l[8];
            end
        end else begin
            t = {1'b0, a} + {1'b0, bx} + {64'd0, ci};
            e.sum = t[63:0];
            for (int k = 0; k < 8; k++) begin
                n = 64 - 8 * k;
                m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
                t = {1'b0, a & m} + {1'b0, bx & m} + {64'd0, ci};
                e.co[7-k] = t[n];
            end
            e.ovf = (a[63] == bx[63]) && (e.sum[63] != a[63]);
        end
        return e;
    endfunction

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return '1;
            1: return 64'd0;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input logic sub, input logic simd, input bit use_exp,
                        input logic [63:0] es, input logic [7:0] ec, input logic eo);
        exp_t e;
        bit   ok;
        e = model(a, b, cin, sub, simd);
        if (use_exp) begin
            e.sum = es;
            e.co  = ec;
            e.ovf = eo;
        end
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_cin   = cin;
        bus.i_sub   = sub;
        bus.i_simd  = simd;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            #1;
            if (lat_mode && t == 0) chk("throughput_i_ready", 64'(bus.i_ready), 64'd1);
            if (bus.i_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        e.cyc = cyc;
        e.chk_lat = lat_mode;
        if (ok) begin
            sb.push_back(e);
            n_push++;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_a     = {$urandom, $urandom};
        bus.i_b     = {$urandom, $urandom};
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        bus.o_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.o_ready = (ready_sel == 2) ? 1'($urandom_range(0, 1)) : (ready_sel == 1);
        end
    end

    // Monitor: values here are the ones the next rising edge will sample.
    initial begin
        exp_t        e;
        logic [63:0] act_sum;
        logic [7:0]  act_co;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.o_valid) begin
                act_sum = bus.o_sum;
                act_co  = bus.o_co;
                if (sb.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_result: got sum %h with nothing outstanding", act_sum);
                end else if (!bus.o_ready) begin
                    chk("stall_sum", act_sum, sb[0].sum);
                    chk("stall_co", 64'(act_co), 64'(sb[0].co));
                end else begin
                    e = sb.pop_front();
                    n_pop++;
                    chk("sum", act_sum, e.sum);
                    chk("co", 64'(act_co), 64'(e.co));
                    chk("ovf", 64'(bus.o_ovf), 64'(e.ovf));
                    if (e.chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_cin = 1'b0;
        bus.i_sub = 1'b0;
        bus.i_simd = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_o_valid", 64'(bus.o_valid), 64'd0);
        chk("reset_o_sum", bus.o_sum, 64'd0);
        chk("reset_o_co", 64'(bus.o_co), 64'd0);
        chk("reset_o_ovf", 64'(bus.o_ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_i_ready", 64'(bus.i_ready), 64'd1);

        // Directed corner cases, back to back, consumer always ready.
        ready_sel = 1;
        lat_mode = 1'b1;
        send('1, 64'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 8'hFF, 1'b0);
        send(64'd5, 64'd7, 1'b0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 8'h00, 1'b0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 1'b1,
             64'h8000_0000_0000_0000, 8'h7F, 1'b1);
        send('1, 64'h0101_0101_0101_0101, 1'b0, 1'b0, 1'b1, 1'b1, 64'd0, 8'hFF, 1'b0);
        send('1, 64'h0101_0101_0101_0101, 1'b0, 1'b0, 1'b0, 1'b1,
             64'h0101_0101_0101_0100, 8'hFF, 1'b0);
        for (int i = 0; i < 500; i++)
            send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0);
        idle();
        drain();
        lat_mode = 1'b0;

        // Back-pressure: two fill the pipe, the third waits for the first pop.
        ready_sel = 0;
        send(64'd10, 64'd20, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        send(64'd30, 64'd40, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        bus.i_a = 64'd50;
        bus.i_b = 64'd60;
        bus.i_cin = 1'b0;
        bus.i_sub = 1'b1;
        bus.i_simd = 1'b0;
        bus.i_valid = 1'b1;
        #1;
        chk("bp_full_i_ready", 64'(bus.i_ready), 64'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("bp_hold_i_ready", 64'(bus.i_ready), 64'd0);
        end
        ready_sel = 1;
        @(negedge clk);
        #1;
        chk("bp_pop_push_i_ready", 64'(bus.i_ready), 64'd1);
        chk("bp_pop_o_valid", 64'(bus.o_valid), 64'd1);
        sb.push_back(model(64'd50, 64'd60, 1'b0, 1'b1, 1'b0));
        n_push++;
        repeat (2) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            #1;
            chk("bp_drain_o_valid", 64'(bus.o_valid), 64'd1);
        end
        drain();

        // Reset with two operations in flight.
        ready_sel = 0;
        send(64'd1, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        send(64'd3, 64'd4, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("midrst_o_sum", bus.o_sum, 64'd0);
        chk("midrst_o_co", 64'(bus.o_co), 64'd0);
        chk("midrst_o_ovf", 64'(bus.o_ovf), 64'd0);
        n_push -= sb.size();
        sb.delete();
        ready_sel = 1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_i_ready", 64'(bus.i_ready), 64'd1);
        repeat (4) idle();

        // Random stream with random consumer stalls and producer gaps.
        ready_sel = 2;
        for (int i = 0; i < 500; i++) begin
            send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        ready_sel = 1;
        drain();
        chk("pop_count", 64'(n_pop), 64'(n_push));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
